led_seq_cpu: RTL and testbench
==============================

Name: led_seq_cpu

Overview:
- Tick-driven LED sequencer CPU that sits directly downstream of the delay/tick generator.
- Executes one instruction from an external program ROM per tick pulse and drives the LED bank from an internal pattern register.
- Provides loop counting, jumps and halt, so animation programs run at the tick rate.

Parameters:
DATA_W, 8, LED/pattern width and immediate width
PC_W, 4, program counter width (ROM depth 2^PC_W); constraint PC_W <= DATA_W
INSTR_W, 4+DATA_W, instruction width; derived, do not override

Ports:
dclk  in  1  clock
rst  in  1  synchronous, active-high reset
tick  in  1  one-cycle step enable from the delay block
run  in  1  1 = execute on tick, 0 = pause (tick ignored)
rom_addr  out  PC_W  program ROM address, equal to pc
rom_data  in  INSTR_W  instruction at rom_addr, combinational read
led  out  DATA_W  pattern register
halted  out  1  1 after HALT executes
pc_out  out  PC_W  current pc, debug

Behaviour:
- Reset (rst=1 at a dclk edge): pc=0, led=0, cnt=0, halted=0, state=RUN. rst has priority over every other input.
- States:
  - RUN: a step occurs at each dclk edge with tick=1, run=1 and rst=0.
  - HALT: no steps occur; the only exit is rst.
- Step:
  - The instruction is rom_data sampled at the step edge; rom_addr=pc.
  - opcode=rom_data[INSTR_W-1:DATA_W]; imm=rom_data[DATA_W-1:0]; target=imm[PC_W-1:0].
  - Results are registered: led, pc, cnt and halted update at the same edge, so they are visible the cycle after tick.
- Opcodes (pc<=pc+1 unless stated; pc+1 wraps from 2^PC_W-1 to 0):
  - 0 NOP: no effect.
  - 1 LDI: led<=imm.
  - 2 SHL: led<=led<<1, LSB filled with 0.
  - 3 SHR: led<=led>>1, MSB filled with 0.
  - 4 ROL: rotate left; MSB goes to LSB.
  - 5 ROR: rotate right; LSB goes to MSB.
  - 6 INV: led<=~led.
  - 7 JMP: pc<=target.
  - 8 LDC: cnt<=imm. cnt is DATA_W bits and internal.
  - 9 DJNZ: cnt<=cnt-1 (modulo 2^DATA_W). If cnt-1 != 0, pc<=target; otherwise pc<=pc+1. With cnt=0 the decrement wraps to 2^DATA_W-1 and the jump is taken.
  - A HALT: halted<=1, state<=HALT, pc unchanged, led unchanged.
  - B-F: treated as NOP.
- Pause: with run=0 all registers hold and ticks are dropped, not queued. When run returns to 1, the next tick executes the instruction at the held pc.
- tick held high for several cycles: one step per cycle. The block does not edge-detect.
- In HALT, tick and run are ignored; all outputs hold.
- Reset mid-program (any state, including a tick in the same cycle): the reset values win and no instruction executes that cycle.
- tick does not need to be registered internally. Only the ~1/3.1M tick duty at full system level is assumed; correctness must not depend on it.

Test Plan:
- Reset then step: ROM[0]=LDI 0xA5, pulse tick once -> led=0xA5 and pc=1 the cycle after tick. Without a tick, led stays 0x00.
- Shift/rotate: program LDI 0x81, ROL, ROR, SHL, SHR, INV -> led sequence 0x81, 0x03, 0x81, 0x02, 0x01, 0xFE across 6 ticks.
- Loop: LDI 0x01, LDC 3, ROL, DJNZ 2, HALT -> after the loop, led=0x08 and halted=1 at pc=4. Further ticks change nothing.
- Pause: run=0 for 5 ticks mid-program -> led and pc unchanged. With run=1, the next tick executes the held instruction.
- Wrap and DJNZ edge: 16 NOPs -> pc wraps 15->0. LDC 0 then DJNZ -> jump taken, cnt=0xFF.
- Reset priority: assert rst coincident with tick while halted=1 -> pc=0, led=0, halted=0. The next tick executes ROM[0].

Source files
------------

// File: rtl/led_seq_cpu.sv
// led_seq_cpu: tick-driven LED sequencer CPU.
// It executes one instruction from an external program ROM on each step.
// A step is a dclk edge with tick=1 and run=1 while in RUN.
// The LED bank is driven from an internal pattern register.
// Ports:
//   dclk      clock
//   rst       synchronous active-high reset; has priority over all other inputs
//   tick      one-cycle step enable
//   run       1 = execute on tick, 0 = pause (ticks are dropped)
//   rom_addr  program ROM address; always equal to pc
//   rom_data  instruction at rom_addr, {opcode[3:0], imm[DATA_W-1:0]}
//   led       pattern register
//   halted    set once HALT executes; cleared only by rst
//   pc_out    current pc, for debug
module led_seq_cpu #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PC_W   = 4
) (
  input  logic              dclk,
  input  logic              rst,
  input  logic              tick,
  input  logic              run,
  output logic [PC_W-1:0]   rom_addr,
  input  logic [DATA_W+3:0] rom_data,
  output logic [DATA_W-1:0] led,
  output logic              halted,
  output logic [PC_W-1:0]   pc_out
);

  localparam int unsigned INSTR_W = 4 + DATA_W;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_SHL  = 4'h2;
  localparam logic [3:0] OP_SHR  = 4'h3;
  localparam logic [3:0] OP_ROL  = 4'h4;
  localparam logic [3:0] OP_ROR  = 4'h5;
  localparam logic [3:0] OP_INV  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_LDC  = 4'h8;
  localparam logic [3:0] OP_DJNZ = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hA;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_led;
  logic [DATA_W-1:0] r_cnt;
  logic              r_halted;

  state_t            w_state_nxt;
  logic [PC_W-1:0]   w_pc_nxt;
  logic [DATA_W-1:0] w_led_nxt;
  logic [DATA_W-1:0] w_cnt_nxt;
  logic              w_halted_nxt;

  logic              w_step;
  logic [3:0]        w_opcode;
  logic [DATA_W-1:0] w_imm;
  logic [PC_W-1:0]   w_target;
  logic [PC_W-1:0]   w_pc_inc;
  logic [DATA_W-1:0] w_cnt_dec;

  // Instruction fields and shared arithmetic
  assign w_opcode  = rom_data[INSTR_W-1:DATA_W];
  assign w_imm     = rom_data[DATA_W-1:0];
  assign w_target  = w_imm[PC_W-1:0];
  assign w_pc_inc  = r_pc + PC_W'(1);
  assign w_cnt_dec = r_cnt - DATA_W'(1);
  assign w_step    = tick && run && (r_state == S_RUN);

  // State and datapath registers
  always_ff @(posedge dclk) begin
    if (rst) begin
      r_state  <= S_RUN;
      r_pc     <= '0;
      r_led    <= '0;
      r_cnt    <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_led    <= w_led_nxt;
      r_cnt    <= w_cnt_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  // Next-state and instruction execute
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_led_nxt    = r_led;
    w_cnt_nxt    = r_cnt;
    w_halted_nxt = r_halted;

    if (w_step) begin
      w_pc_nxt = w_pc_inc;
      case (w_opcode)
        OP_NOP: ;
        OP_LDI: w_led_nxt = w_imm;
        OP_SHL: w_led_nxt = {r_led[DATA_W-2:0], 1'b0};
        OP_SHR: w_led_nxt = {1'b0, r_led[DATA_W-1:1]};
        OP_ROL: w_led_nxt = {r_led[DATA_W-2:0], r_led[DATA_W-1]};
        OP_ROR: w_led_nxt = {r_led[0], r_led[DATA_W-1:1]};
        OP_INV: w_led_nxt = ~r_led;
        OP_JMP: w_pc_nxt  = w_target;
        OP_LDC: w_cnt_nxt = w_imm;
        // Loop while the decremented count is nonzero; a count of 0 wraps and loops.
        OP_DJNZ: begin
          w_cnt_nxt = w_cnt_dec;
          if (w_cnt_dec != '0) w_pc_nxt = w_target;
        end
        OP_HALT: begin
          w_pc_nxt     = r_pc;
          w_halted_nxt = 1'b1;
          w_state_nxt  = S_HALT;
        end
        default: ;
      endcase
    end
  end

  assign rom_addr = r_pc;
  assign pc_out   = r_pc;
  assign led      = r_led;
  assign halted   = r_halted;

endmodule

// File: tb/tb_led_seq_cpu.sv
// tb_led_seq_cpu: directed scoreboard bench for led_seq_cpu.
// Each step pushes the expected {led, pc, rom_addr, halted} to a queue.
// It then pops that entry and checks it once the edge has produced the DUT output.
module tb_led_seq_cpu;

  logic        dclk;
  logic        rst;
  logic        tick;
  logic        run;
  logic [3:0]  rom_addr;
  logic [11:0] rom_data;
  logic [7:0]  led;
  logic        halted;
  logic [3:0]  pc_out;

  logic [11:0] rom [16];

  typedef struct packed {
    logic [7:0] led;
    logic [3:0] pc;
    logic [3:0] addr;
    logic       halted;
  } obs_t;

  obs_t sb [$];
  int   vectors     = 0;
  int   miscompares = 0;

  led_seq_cpu #(.DATA_W(8), .PC_W(4)) dut (
    .dclk     (dclk),
    .rst      (rst),
    .tick     (tick),
    .run      (run),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .led      (led),
    .halted   (halted),
    .pc_out   (pc_out)
  );

  assign rom_data = rom[rom_addr];

  always #5 dclk = ~dclk;

  function automatic logic [11:0] ins(input logic [3:0] op, input logic [7:0] imm);
    return {op, imm};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 12'h000;
  endtask

  // One clock: drive inputs, queue the expectation, check after the edge
  task automatic step(input logic t, input logic r, input logic rs,
                      input logic [7:0] el, input logic [3:0] ep, input logic eh,
                      input string tag);
    obs_t exp_v;
    obs_t obs_v;
    @(negedge dclk);
    tick = t;
    run  = r;
    rst  = rs;
    sb.push_back({el, ep, ep, eh});
    @(posedge dclk);
    #1;
    exp_v = sb.pop_front();
    obs_v = {led, pc_out, rom_addr, halted};
    vectors++;
    assert (obs_v === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed led=%h pc=%h addr=%h halted=%b expected led=%h pc=%h addr=%h halted=%b",
             tag, obs_v.led, obs_v.pc, obs_v.addr, obs_v.halted,
             exp_v.led, exp_v.pc, exp_v.addr, exp_v.halted);
    end
  endtask

  initial begin
    dclk = 1'b0;
    rst  = 1'b1;
    tick = 1'b0;
    run  = 1'b0;
    clear_rom();

    // Reset then a single step
    rom[0] = ins(4'h1, 8'hA5);
    step(0, 0, 1, 8'h00, 4'd0, 0, "reset");
    step(0, 1, 0, 8'h00, 4'd0, 0, "no_tick_hold");
    step(1, 1, 0, 8'hA5, 4'd1, 0, "ldi_a5");
    step(0, 1, 0, 8'hA5, 4'd1, 0, "ldi_a5_hold");

    // Shift/rotate chain with a pause in the middle; tick stays high across steps
    clear_rom();
    rom[0] = ins(4'h1, 8'h81);
    rom[1] = ins(4'h4, 8'h00);
    rom[2] = ins(4'h5, 8'h00);
    rom[3] = ins(4'h2, 8'h00);
    rom[4] = ins(4'h3, 8'h00);
    rom[5] = ins(4'h6, 8'h00);
    step(0, 0, 1, 8'h00, 4'd0, 0, "reset_shift");
    step(1, 1, 0, 8'h81, 4'd1, 0, "sh_ldi");
    step(1, 1, 0, 8'h03, 4'd2, 0, "sh_rol");
    step(1, 1, 0, 8'h81, 4'd3, 0, "sh_ror");
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'h81, 4'd3, 0, "pause");
    step(1, 1, 0, 8'h02, 4'd4, 0, "sh_shl_after_pause");
    step(1, 1, 0, 8'h01, 4'd5, 0, "sh_shr");
    step(1, 1, 0, 8'hFE, 4'd6, 0, "sh_inv");

    // Counted loop ending in HALT
    clear_rom();
    rom[0] = ins(4'h1, 8'h01);
    rom[1] = ins(4'h8, 8'h03);
    rom[2] = ins(4'h4, 8'h00);
    rom[3] = ins(4'h9, 8'h02);
    rom[4] = ins(4'hA, 8'h00);
    step(0, 0, 1, 8'h00, 4'd0, 0, "reset_loop");
    step(1, 1, 0, 8'h01, 4'd1, 0, "lp_ldi");
    step(1, 1, 0, 8'h01, 4'd2, 0, "lp_ldc");
    step(1, 1, 0, 8'h02, 4'd3, 0, "lp_rol1");
    step(1, 1, 0, 8'h02, 4'd2, 0, "lp_djnz1");
    step(1, 1, 0, 8'h04, 4'd3, 0, "lp_rol2");
    step(1, 1, 0, 8'h04, 4'd2, 0, "lp_djnz2");
    step(1, 1, 0, 8'h08, 4'd3, 0, "lp_rol3");
    step(1, 1, 0, 8'h08, 4'd4, 0, "lp_djnz_exit");
    step(1, 1, 0, 8'h08, 4'd4, 1, "lp_halt");
    step(1, 1, 0, 8'h08, 4'd4, 1, "halt_hold1");
    step(1, 0, 0, 8'h08, 4'd4, 1, "halt_hold2");
    step(1, 1, 0, 8'h08, 4'd4, 1, "halt_hold3");

    // Reset coincident with tick while halted
    step(1, 1, 1, 8'h00, 4'd0, 0, "rst_priority");
    step(1, 1, 0, 8'h01, 4'd1, 0, "post_rst_rom0");

    // pc wrap across 16 NOPs
    clear_rom();
    step(0, 0, 1, 8'h00, 4'd0, 0, "reset_wrap");
    for (int i = 1; i <= 16; i++) step(1, 1, 0, 8'h00, 4'(i), 0, "wrap");

    // DJNZ with cnt=0 wraps to 0xFF and jumps
    rom[0] = ins(4'h8, 8'h00);
    rom[1] = ins(4'h9, 8'h05);
    step(0, 0, 1, 8'h00, 4'd0, 0, "reset_djnz");
    step(1, 1, 0, 8'h00, 4'd1, 0, "ldc0");
    step(1, 1, 0, 8'h00, 4'd5, 0, "djnz_zero_jump");
    vectors++;
    assert (dut.r_cnt === 8'hFF) else begin
      miscompares++;
      $error("FAIL djnz_cnt_wrap: observed cnt=%h expected cnt=ff", dut.r_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
